bit_serial_addsub: RTL and testbench
====================================

# bit_serial_addsub

Sequential, bit-serial two's-complement adder/subtractor. Drives the XOR3 sum path in the opposite direction: it owns operand sequencing (A, B, Sub), carry-save state and result collection for the per-bit domino XOR3 stage. It accepts a parallel operand pair on a Start strobe and processes one bit per clock, LSB first. It returns a parallel result with carry-out and signed overflow on a one-cycle Done pulse. It sits between the register file/operand latches and the result bus of the adder datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  reset, asynchronous, active-high
- Start  input  1  request strobe; sampled only in IDLE or DONE
- Sub  input  1  0 = A+B, 1 = A−B; sampled with Start
- A  input  WIDTH  operand A; sampled with Start
- B  input  WIDTH  operand B; sampled with Start
- Busy  output  1  high while bits are being processed
- Done  output  1  one-cycle completion pulse
- Y  output  WIDTH  result, registered, held between operations
- Cout  output  1  carry out of MSB (for Sub: 1 = no borrow)
- Ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: Busy=0, Done=0. Start=1 → load shift registers with A, B, and latch Sub. Set carry=Sub and bit counter=0. Go to RUN.
- RUN, each edge: a=A_sh[0], b=B_sh[0]^Sub_l. Sum bit = a^b^carry, new carry = majority(a,b,carry). Shift A_sh/B_sh right. Shift the sum bit into the MSB of the internal result register. Counter +1.
- At counter==WIDTH−1, the RUN edge processes the final bit. On that edge, Y ← full result, Cout ← final carry, Ovf ← (carry entering MSB) XOR (final carry). State → DONE.
- DONE: Done=1, Busy=0, lasts exactly one cycle. Start=1 in DONE → new load, go to RUN (back-to-back). Otherwise → IDLE.
- Start while in RUN is ignored; operands are not re-sampled.
- Y/Cout/Ovf change only on the completion edge and hold through subsequent RUN phases.
- Counter width: clog2(WIDTH). No wrap is visible; the counter is reloaded on every Start.

## Timing
- Reset (async, immediate): state IDLE, Busy=0, Done=0, Y=0, Cout=0, Ovf=0, internal registers cleared.
- Rst asserted mid-RUN: operation is aborted, no Done is produced, and outputs are zero. The first rising edge with Rst low behaves as in IDLE.
- Latency: Start sampled at edge E0 → Busy=1 after E0. Done=1 and the new Y are valid after edge E0+WIDTH. Done falls after E0+WIDTH+1.
- Throughput: one operation per WIDTH+1 cycles with continuous Start.
- Busy and Done are never high simultaneously.

## Test plan
- Reset: assert Rst asynchronously between edges → Busy, Done, Y, Cout, Ovf all 0 before the next edge.
- Add (WIDTH=8): A=0x5A, B=0x3C, Sub=0, Start pulse → Done exactly 8 cycles after the sampling edge, Y=0x96, Cout=0, Ovf=1.
- Add wrap: A=0xFF, B=0x01, Sub=0 → Y=0x00, Cout=1, Ovf=0.
- Subtract: A=0x10, B=0x20, Sub=1 → Y=0xF0, Cout=0, Ovf=0. Then A=0x80, B=0x01, Sub=1 → Y=0x7F, Cout=1, Ovf=1.
- Start held high continuously with operands changed mid-RUN → changes are ignored during RUN. Back-to-back results are Done-spaced 9 cycles apart, and each Y matches the operands sampled at its Start.
- Rst pulse at the 3rd RUN cycle of 0x5A+0x3C → no Done, Y=0. A fresh 0x01+0x02 afterwards completes normally with Y=0x03.

Source files
------------

// File: rtl/bit_serial_addsub_if.sv
// Operand/result bundle between the operand latches and the bit-serial adder/subtractor.
// The master side issues start/sub/a/b; the slave side returns status and the parallel result.
interface bit_serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, y, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, y, cout, ovf
  );
endinterface

// File: rtl/bit_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor that processes one bit per clock, LSB first.
// The parallel result, carry-out and signed overflow are published with a one-cycle done pulse.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  bit_serial_addsub_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] bit_cnt;
  logic             sub_l;
  logic             carry;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] y_r;
  logic             cout_r;
  logic             ovf_r;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;

  // Subtraction is A + ~B + 1: B is inverted bit by bit and the +1 enters as the initial carry.
  assign a_bit      = a_sh[0];
  assign b_bit      = b_sh[0] ^ sub_l;
  assign sum_bit    = a_bit ^ b_bit ^ carry;
  assign carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
  assign res_next   = {sum_bit, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      bit_cnt <= '0;
      sub_l   <= 1'b0;
      carry   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            sub_l   <= bus.sub;
            carry   <= bus.sub;
            bit_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          carry  <= carry_next;
          // On the MSB edge the carry register still holds the carry entering the MSB.
          if (bit_cnt == LAST_BIT) begin
            y_r    <= res_next;
            cout_r <= carry_next;
            ovf_r  <= carry ^ carry_next;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.y    = y_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub: vector table, random ops, back-to-back starts and reset abort.
// Expected results go to a scoreboard queue when a start is driven and are popped on each done pulse.
module tb_bit_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  bit_serial_addsub_if #(.WIDTH(W)) bus ();

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: widen, add, and derive overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = b_v ^ {W{sub_v}};
    full   = {1'b0, a_v} + {1'b0, bb} + {{W{1'b0}}, sub_v};
    e.y    = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a_v[W-1] == bb[W-1]) && (full[W-1] != a_v[W-1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the next posedge samples the start.
  task automatic apply_stimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                input logic sub_v, input exp_t e);
    exp_t ee;
    ee       = e;
    ee.cyc   = cyc + 1 + W;
    bus.a    = a_v;
    bus.b    = b_v;
    bus.sub  = sub_v;
    bus.start = 1'b1;
    sb.push_back(ee);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL %s: unexpected done, got 1 want 0", tag);
        end else begin
          e = sb.pop_front();
          check_output({tag, "_y"}, 32'(bus.y), 32'(e.y));
          check_output({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
          check_output({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
          check_output({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
          check_output({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done want done within %0d cycles", tag, 4 * W);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    vec_t         vecs[7];
    exp_t         e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W-1:0] b2b_a[4];
    logic [W-1:0] b2b_b[4];
    logic         b2b_s[4];
    int           prev_cyc;
    int           done_cnt;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, y: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, y: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, y: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, y: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, sub: 1'b1, y: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, y: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, y: 8'h00, cout: 1'b1, ovf: 1'b1};

    b2b_a[0] = 8'h12; b2b_b[0] = 8'h34; b2b_s[0] = 1'b0;
    b2b_a[1] = 8'hF0; b2b_b[1] = 8'h0F; b2b_s[1] = 1'b1;
    b2b_a[2] = 8'h55; b2b_b[2] = 8'hAA; b2b_s[2] = 1'b0;
    b2b_a[3] = 8'h11; b2b_b[3] = 8'h22; b2b_s[3] = 1'b0;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #12;
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_y", 32'(bus.y), 32'd0);
    check_output("reset_cout", 32'(bus.cout), 32'd0);
    check_output("reset_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      e = '{y: vecs[i].y, cout: vecs[i].cout, ovf: vecs[i].ovf, cyc: 0};
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub, e);
      wait_done($sformatf("vec%0d", i));
    end

    $display("[TB] random operands");
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      apply_stimulus(ra, rb, rs, model(ra, rb, rs));
      wait_done($sformatf("rnd%0d", i));
    end

    $display("[TB] back-to-back with start held");
    bus.a     = b2b_a[0];
    bus.b     = b2b_b[0];
    bus.sub   = b2b_s[0];
    bus.start = 1'b1;
    e         = model(b2b_a[0], b2b_b[0], b2b_s[0]);
    e.cyc     = cyc + 1 + W;
    prev_cyc  = e.cyc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k < 4; k++) begin
      bus.a    = b2b_a[k];
      bus.b    = b2b_b[k];
      bus.sub  = b2b_s[k];
      e        = model(b2b_a[k], b2b_b[k], b2b_s[k]);
      e.cyc    = prev_cyc + W + 1;
      prev_cyc = e.cyc;
      sb.push_back(e);
      wait_done($sformatf("b2b%0d", k - 1));
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_done("b2b3");

    $display("[TB] reset abort mid-run");
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_done", 32'(bus.done), 32'd0);
    check_output("abort_y", 32'(bus.y), 32'd0);
    check_output("abort_cout", 32'(bus.cout), 32'd0);
    check_output("abort_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    check_output("abort_y_held", 32'(bus.y), 32'd0);

    e = '{y: 8'h03, cout: 1'b0, ovf: 1'b0, cyc: 0};
    apply_stimulus(8'h01, 8'h02, 1'b0, e);
    wait_done("after_abort");

    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
